// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Latency: instruction at PC=A appears on inst_id one cycle later; Imem_addr/inst_if are combinational.
// Backpressure: Stall holds PC and IF/ID; Flush/Redirect squash IF/ID to a bubble; Redirect wins over Stall.
//
// Ports:
//   Clock, Reset            - single rising-edge clock, synchronous active-high reset
//   Stall, Flush            - hazard-unit controls (hold / squash IF/ID)
//   Redirect, Redirect_target - resolved taken branch/jump and its target
//   Imem_data / Imem_addr   - combinational instruction memory read port (Imem_addr == PC)
//   PC, inst_if             - current fetch PC and the raw fetched word
//   inst_id, pc4_id, valid_id - IF/ID register contents for decode
//   Addr_err                - one-cycle pulse after a misaligned redirect
//   Fetch_cnt, Stall_cnt, Flush_cnt - performance counters
//
// Build option: define IF_STAGE_PERF_EN to implement the performance counters.
// Without it the counter ports stay present and read constant zero.

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] Redirect_target,
    input  logic [31:0] Imem_data,
    output logic [31:0] Imem_addr,
    output logic [31:0] PC,
    output logic [31:0] inst_if,
    output logic [31:0] inst_id,
    output logic [31:0] pc4_id,
    output logic        valid_id,
    output logic        Addr_err,
    output logic [31:0] Fetch_cnt,
    output logic [31:0] Stall_cnt,
    output logic [31:0] Flush_cnt
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_inst_id;
    logic [31:0] r_pc4_id;
    logic        r_valid_id;
    logic        r_addr_err;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_next;
    logic        w_hold;       // stall that actually freezes the front end
    logic        w_bubble;     // IF/ID receives a bubble this cycle
    logic        w_load;       // IF/ID receives a real instruction this cycle
    logic        w_misalign;   // redirect target not word aligned

    // Natural 32-bit wrap: FFFF_FFFC + 4 = 0000_0000.
    assign w_pc_plus4    = r_pc + 32'd4;

    // Low two bits are dropped rather than trapping here; the error is
    // reported separately through Addr_err.
    assign w_redirect_pc = {Redirect_target[31:2], 2'b00};
    assign w_misalign    = Redirect && (Redirect_target[1:0] != 2'b00);

    // A redirect always makes progress, so a stall only holds when no
    // redirect is present.
    assign w_hold        = Stall && !Redirect;

    // Squash overrides a hold: the younger instruction in IF/ID is on the
    // wrong path (redirect) or explicitly killed (flush).
    assign w_bubble      = Flush || Redirect;
    assign w_load        = !w_bubble && !w_hold;

    // Next-PC priority below reset: Redirect > Stall > sequential.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (Redirect) begin
            w_pc_next = w_redirect_pc;
        end else if (Stall) begin
            w_pc_next = r_pc;
        end
    end

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_inst_id  <= 32'h0;
            r_pc4_id   <= 32'h0;
            r_valid_id <= 1'b0;
        end else if (w_bubble) begin
            r_inst_id  <= 32'h0;
            r_pc4_id   <= 32'h0;
            r_valid_id <= 1'b0;
        end else if (w_load) begin
            r_inst_id  <= Imem_data;
            r_pc4_id   <= w_pc_plus4;
            r_valid_id <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Misaligned-redirect flag: registered, so it is high for exactly the
    // cycle after the offending redirect and clears on its own.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_misalign;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef IF_STAGE_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // All three wrap modulo 2^32. A stall that coincides with a flush still
    // counts as a stall cycle: the PC is held even though IF/ID is squashed.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_fetch_cnt <= 32'h0;
            r_stall_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (w_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_hold) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_bubble) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign Fetch_cnt = r_fetch_cnt;
    assign Stall_cnt = r_stall_cnt;
    assign Flush_cnt = r_flush_cnt;
`else
    assign Fetch_cnt = 32'h0;
    assign Stall_cnt = 32'h0;
    assign Flush_cnt = 32'h0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign PC        = r_pc;
    assign Imem_addr = r_pc;
    assign inst_if   = Imem_data;
    assign inst_id   = r_inst_id;
    assign pc4_id    = r_pc4_id;
    assign valid_id  = r_valid_id;
    assign Addr_err  = r_addr_err;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    int total = 0;
    int bad   = 0;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- instance A: RESET_PC = 0 ----------------
    logic        Reset = 1'b1, Stall = 1'b0, Flush = 1'b0, Redirect = 1'b0;
    logic [31:0] Redirect_target = 32'h0;
    logic [31:0] a_imem_data, a_imem_addr, a_pc, a_inst_if, a_inst_id, a_pc4_id;
    logic        a_valid_id, a_addr_err;
    logic [31:0] a_fc, a_sc, a_fl;

    // ROM: word[i] = i + 1 over the whole address space
    assign a_imem_data = (a_imem_addr >> 2) + 32'd1;

    if_stage #(.RESET_PC(32'h0000_0000)) dut_a (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .Redirect(Redirect), .Redirect_target(Redirect_target),
        .Imem_data(a_imem_data), .Imem_addr(a_imem_addr), .PC(a_pc),
        .inst_if(a_inst_if), .inst_id(a_inst_id), .pc4_id(a_pc4_id),
        .valid_id(a_valid_id), .Addr_err(a_addr_err),
        .Fetch_cnt(a_fc), .Stall_cnt(a_sc), .Flush_cnt(a_fl)
    );

    // ---------------- instance B: RESET_PC near the top ----------------
    logic        b_rst = 1'b1;
    logic [31:0] b_imem_data, b_imem_addr, b_pc, b_inst_if, b_inst_id, b_pc4_id;
    logic        b_valid_id, b_addr_err;
    logic [31:0] b_fc, b_sc, b_fl;

    assign b_imem_data = (b_imem_addr >> 2) + 32'd1;

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .Clock(Clock), .Reset(b_rst), .Stall(1'b0), .Flush(1'b0),
        .Redirect(1'b0), .Redirect_target(32'h0),
        .Imem_data(b_imem_data), .Imem_addr(b_imem_addr), .PC(b_pc),
        .inst_if(b_inst_if), .inst_id(b_inst_id), .pc4_id(b_pc4_id),
        .valid_id(b_valid_id), .Addr_err(b_addr_err),
        .Fetch_cnt(b_fc), .Stall_cnt(b_sc), .Flush_cnt(b_fl)
    );

    // ---------------- reference model for instance A ----------------
    logic [31:0] m_pc = 32'h0, m_inst = 32'h0, m_pc4 = 32'h0;
    logic        m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_fc = 32'h0, m_sc = 32'h0, m_fl = 32'h0;

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef IF_STAGE_PERF_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    // One clock of the fetch-stage rules, applied to the current inputs.
    task automatic model_step();
        logic [31:0] word;
        logic        squash, held;
        word = (m_pc / 4) + 1;
        if (Reset) begin
            m_pc = 32'h0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
            m_fc = 0; m_sc = 0; m_fl = 0;
        end else begin
            squash = Flush || Redirect;
            held   = Stall && !Redirect;
            m_err  = Redirect && (Redirect_target % 4 != 0);
            if (squash) begin
                m_inst = 0; m_pc4 = 0; m_valid = 0; m_fl = m_fl + 1;
            end else if (!held) begin
                m_inst = word; m_pc4 = m_pc + 4; m_valid = 1; m_fc = m_fc + 1;
            end
            if (held) m_sc = m_sc + 1;
            if (Redirect)   m_pc = Redirect_target - (Redirect_target % 4);
            else if (!held) m_pc = m_pc + 4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, stall, flush, redir;
        logic [31:0] tgt;
        logic [31:0] e_pc, e_inst, e_pc4;
        logic        e_valid, e_err;
        logic [31:0] e_fc, e_sc, e_fl;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic rst, stall, flush, redir, input logic [31:0] tgt,
                                input logic [31:0] pc, inst, pc4, input logic valid, err,
                                input logic [31:0] fc, sc, fl);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.redir = redir; v.tgt = tgt;
        v.e_pc = pc; v.e_inst = inst; v.e_pc4 = pc4; v.e_valid = valid; v.e_err = err;
        v.e_fc = fc; v.e_sc = sc; v.e_fl = fl;
        return v;
    endfunction

    initial begin
        //            rst st fl rd tgt      pc      inst   pc4     v  e  fc sc fl
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,  32'h00, 32'h0,  32'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 32'h0,  32'h00, 32'h0,  32'h00, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,  32'h04, 32'h1,  32'h04, 1, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,  32'h08, 32'h2,  32'h08, 1, 0, 2, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 32'h0,  32'h08, 32'h2,  32'h08, 1, 0, 2, 1, 0);
        tbl[5]  = mk(0, 1, 0, 0, 32'h0,  32'h08, 32'h2,  32'h08, 1, 0, 2, 2, 0);
        tbl[6]  = mk(0, 1, 0, 0, 32'h0,  32'h08, 32'h2,  32'h08, 1, 0, 2, 3, 0);
        tbl[7]  = mk(0, 1, 0, 1, 32'h40, 32'h40, 32'h0,  32'h00, 0, 0, 2, 3, 1);
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,  32'h44, 32'h11, 32'h44, 1, 0, 3, 3, 1);
        tbl[9]  = mk(0, 0, 0, 1, 32'h43, 32'h40, 32'h0,  32'h00, 0, 1, 3, 3, 2);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,  32'h44, 32'h11, 32'h44, 1, 0, 4, 3, 2);
        tbl[11] = mk(0, 1, 1, 0, 32'h0,  32'h44, 32'h0,  32'h00, 0, 0, 4, 4, 3);
        tbl[12] = mk(0, 1, 0, 0, 32'h0,  32'h44, 32'h0,  32'h00, 0, 0, 4, 5, 3);
        tbl[13] = mk(1, 1, 0, 0, 32'h0,  32'h00, 32'h0,  32'h00, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 32'h0,  32'h04, 32'h1,  32'h04, 1, 0, 1, 0, 0);

        // Phase 1: directed table on instance A (B held in reset)
        @(posedge Clock);
        #1;
        for (int i = 0; i < 15; i++) begin
            Reset = tbl[i].rst; Stall = tbl[i].stall; Flush = tbl[i].flush;
            Redirect = tbl[i].redir; Redirect_target = tbl[i].tgt;
            tick();
            chk($sformatf("tbl%0d pc", i),       a_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d imem_addr", i), a_imem_addr, tbl[i].e_pc);
            chk($sformatf("tbl%0d inst_if", i),   a_inst_if, (tbl[i].e_pc >> 2) + 32'd1);
            chk($sformatf("tbl%0d inst_id", i),   a_inst_id, tbl[i].e_inst);
            chk($sformatf("tbl%0d pc4_id", i),    a_pc4_id, tbl[i].e_pc4);
            chk($sformatf("tbl%0d valid_id", i),  {31'b0, a_valid_id}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d addr_err", i),  {31'b0, a_addr_err}, {31'b0, tbl[i].e_err});
            chk($sformatf("tbl%0d fetch_cnt", i), a_fc, perf(tbl[i].e_fc));
            chk($sformatf("tbl%0d stall_cnt", i), a_sc, perf(tbl[i].e_sc));
            chk($sformatf("tbl%0d flush_cnt", i), a_fl, perf(tbl[i].e_fl));
        end
        Reset = 0; Stall = 0; Flush = 0; Redirect = 0; Redirect_target = 0;

        // Phase 2: PC wrap from RESET_PC = FFFF_FFF8 on instance B
        b_rst = 1'b1;
        tick();
        tick();
        chk("wrap reset pc", b_pc, 32'hFFFF_FFF8);
        chk("wrap reset valid", {31'b0, b_valid_id}, 32'h0);
        b_rst = 1'b0;
        tick();
        chk("wrap c1 pc", b_pc, 32'hFFFF_FFFC);
        chk("wrap c1 inst", b_inst_id, 32'h3FFF_FFFF);
        chk("wrap c1 pc4", b_pc4_id, 32'hFFFF_FFFC);
        tick();
        chk("wrap c2 pc", b_pc, 32'h0000_0000);
        chk("wrap c2 inst", b_inst_id, 32'h4000_0000);
        chk("wrap c2 pc4", b_pc4_id, 32'h0000_0000);
        chk("wrap c2 valid", {31'b0, b_valid_id}, 32'h1);

        // Phase 3: randomized traffic on A against the model
        for (int n = 0; n < 3000; n++) begin
            Reset           = ($urandom_range(0, 99) < 2);
            Stall           = ($urandom_range(0, 99) < 30);
            Flush           = ($urandom_range(0, 99) < 10);
            Redirect        = ($urandom_range(0, 99) < 8);
            Redirect_target = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h3FF);
            tick();
            chk("rnd pc", a_pc, m_pc);
            chk("rnd imem_addr", a_imem_addr, m_pc);
            chk("rnd inst_if", a_inst_if, (m_pc / 4) + 1);
            chk("rnd inst_id", a_inst_id, m_inst);
            chk("rnd pc4_id", a_pc4_id, m_pc4);
            chk("rnd valid_id", {31'b0, a_valid_id}, {31'b0, m_valid});
            chk("rnd addr_err", {31'b0, a_addr_err}, {31'b0, m_err});
            chk("rnd fetch_cnt", a_fc, perf(m_fc));
            chk("rnd stall_cnt", a_sc, perf(m_sc));
            chk("rnd flush_cnt", a_fl, perf(m_fl));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Stall  input  1  from hazard unit; hold PC and IF/ID contents.
REQ-005 SHALL have port Flush  input  1  squash IF/ID contents (insert bubble).
REQ-006 SHALL have port Redirect  input  1  taken branch/jump resolved downstream.
REQ-007 SHALL have port Redirect_target  input  32  next fetch address when Redirect=1.
REQ-008 SHALL have port Imem_data  input  32  combinational instruction memory read data for Imem_addr.
REQ-009 SHALL have port Imem_addr  output  32  fetch address, equal to PC.
REQ-010 SHALL have port PC  output  32  current fetch PC.
REQ-011 SHALL have port inst_if  output  32  Imem_data passed through combinationally.
REQ-012 SHALL have port inst_id  output  32  registered instruction for decode.
REQ-013 SHALL have port pc4_id  output  32  registered PC+4 of inst_id.
REQ-014 SHALL have port valid_id  output  1  1 = inst_id is a real instruction, 0 = bubble.
REQ-015 SHALL have port Addr_err  output  1  one-cycle pulse on misaligned redirect.
REQ-016 SHALL have ports Fetch_cnt, Stall_cnt, Flush_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-017 Next-PC priority SHALL be: Reset > Redirect > Stall > sequential.
REQ-018 Sequential: PC <= PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-019 Redirect=1: PC <= {Redirect_target[31:2],2'b00}, regardless of Stall.
REQ-020 Redirect=1 with Redirect_target[1:0]!=0: Addr_err=1 in the following cycle only; otherwise Addr_err=0.
REQ-021 Stall=1, Redirect=0: PC, inst_id, pc4_id and valid_id SHALL hold.
REQ-022 Normal load: inst_id <= Imem_data, pc4_id <= PC+4, valid_id <= 1.
REQ-023 Flush=1 or Redirect=1: IF/ID SHALL load bubble (inst_id=32'h0, pc4_id=32'h0, valid_id=0); this overrides Stall.
REQ-024 Fetch latency: instruction at address A SHALL appear on inst_id exactly one cycle after PC=A, absent stall/flush.
REQ-025 Imem_addr and inst_if SHALL be purely combinational from PC and Imem_data.

Reset
REQ-026 On Clock edge with Reset=1: PC=RESET_PC, inst_id=0, pc4_id=0, valid_id=0, Addr_err=0, all counters=0.
REQ-027 Reset SHALL override Stall, Flush and Redirect in the same cycle; Reset asserted mid-stall SHALL discard held state.
REQ-028 First cycle after Reset deasserts: PC=RESET_PC, fetch proceeds per REQ-017.

Configuration
REQ-029 Macro IF_STAGE_PERF_EN defined: Fetch_cnt SHALL increment on each cycle IF/ID loads a valid instruction; Stall_cnt on each cycle REQ-021 applies; Flush_cnt on each cycle REQ-023 applies; all wrap at 2^32.
REQ-030 Macro IF_STAGE_PERF_EN undefined: counter ports SHALL remain present and read constant 0; no counter flops.

Verification
REQ-031 Reset=1 for 2 cycles, release, ROM word[i]=i+1 -> PC sequence 0,4,8,12; inst_id=1,2,3 at cycles 2,3,4 after release; valid_id=1 from cycle 2.
REQ-032 Stall=1 for 3 cycles at PC=8 -> PC stays 8, inst_id stays 2, Stall_cnt=3 (macro on), 0 (macro off).
REQ-033 Redirect=1, Redirect_target=32'h40 while Stall=1 -> next PC=32'h40, valid_id=0, inst_id=0; next instruction from 0x40 one cycle later.
REQ-034 Redirect_target=32'h43 -> PC=32'h40, Addr_err high for exactly one cycle.
REQ-035 RESET_PC=32'hFFFF_FFF8, run 3 cycles -> PC FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 Flush=1 and Stall=1 same cycle, then Reset=1 during subsequent stall -> bubble loaded, then all outputs at reset values per REQ-026.
